alu_result_drain: RTL and testbench
===================================

// Module: alu_result_drain
// PURPOSE
//   Consumer end of the vector ALU result interface. Watches the ALU enable/op strobe, captures
//   the registered 16-lane A3 (low/sum) and A4 (high/carry) result vectors one cycle later, and
//   drains them as a stream of 32-bit words over a valid/ready port toward memory writeback.
//   Sits between the vector ALU and the store/writeback path.
// PARAMETERS
//   LANES   16  number of vector lanes (A3/A4 width = LANES*LANE_W)
//   LANE_W  32  lane width in bits; also out_data width
// PORTS
//   clk            in   1             rising-edge clock, shared with the ALU
//   rst_n          in   1             asynchronous active-low reset
//   alu_enable     in   1             same enable the ALU samples; one result per sampled-high cycle
//   alu_op         in   1             same op the ALU samples: 0 = add, 1 = multiply
//   A3             in   LANES*LANE_W  ALU low result vector, lane i = A3[LANE_W*i +: LANE_W]
//   A4             in   LANES*LANE_W  ALU high result vector (carry in bit 0 for add)
//   out_valid      out  1             out_data/out_lane/out_hi hold a word
//   out_ready      in   1             downstream accepts the word when out_valid & out_ready
//   out_data       out  LANE_W        word being offered
//   out_lane       out  $clog2(LANES) lane index of out_data
//   out_hi         out  1             0 = word from A3, 1 = word from A4
//   busy           out  1             high in CAPT and SEND
//   done           out  1             one-cycle pulse after the final word is accepted
//   overflow_drop  out  1             one-cycle pulse: alu_enable seen while busy, result discarded
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; out_valid, out_data, out_lane, out_hi, busy, done,
//     overflow_drop = 0; shadow buffers cleared. Reset mid-drain discards the remaining words.
//   - States: IDLE -> CAPT -> SEND -> IDLE.
//     IDLE: alu_enable=1 at edge E0 -> CAPT; latch alu_op into op_q.
//     CAPT: exactly one cycle; ALU drives the E0 result. At edge E1, latch A3/A4 into shadow
//       buffers, set idx=0, hi=0, out_valid=1 -> SEND. First word is valid the cycle after E1.
//     SEND: out_data = hi ? A4_q[idx] : A3_q[idx]. Word order: A3 lanes 0..LANES-1, then
//       A4 lanes 0..LANES-1, for 2*LANES words in total. On out_valid & out_ready, advance
//       (idx wraps to 0 and hi is set after lane LANES-1). After the last word is accepted,
//       out_valid=0, done=1 for one cycle -> IDLE.
//   - Handshake: once asserted, out_valid stays high and out_data/out_lane/out_hi stay stable
//     until accepted. With out_ready held high, one word transfers per cycle. A word takes
//     2*LANES+1 cycles from E0 to final acceptance at minimum.
//   - alu_enable in CAPT or SEND: result is not captured; overflow_drop pulses on the next cycle.
//     Exception: alu_enable in the same cycle as the final accepted word is taken. done pulses,
//     the next state is CAPT (not IDLE), and overflow_drop stays 0.
//   - Back-to-back enables IDLE->CAPT: the CAPT-cycle enable is dropped (overflow_drop). The E1
//     latch captures the pre-edge A3/A4 value, i.e. the E0 result.
//   - Shadow buffers are used so that later ALU activity never corrupts a drain in progress.
// CONFIGURATION
//   DRAIN_CARRY_PACK_EN defined: when op_q=0 (add), the A4 half is sent as a single word.
//     out_data[i] = A4_q lane i bit 0 for i < LANES, upper bits are 0, out_hi=1, out_lane=0.
//     The drain is LANES+1 words. Multiply (op_q=1) is unchanged at 2*LANES words.
//   Not defined: always 2*LANES words, A4 lanes sent in full regardless of op.
// TESTING
//   1 reset: rst_n=0 mid-SEND (word 5) -> all outputs 0 immediately; IDLE; no done pulse.
//   2 add, ready=1: lane i A1=i, A2=0xFFFFFFFF, pulse enable -> 32 words over 32 consecutive
//     cycles. A3 lane0 = 0xFFFFFFFF, A3 lane i = i-1 for i>=1; A4 lane0 = 0, A4 lane i = 1
//     for i>=1; done pulses once.
//   3 mul backpressure: A1=0x10000, A2=0x30000 all lanes, ready toggled 1/0 -> each A3 word = 0,
//     each A4 word = 3. Data held stable while ready=0; order lane0..15 lo, then hi.
//   4 overflow: enable on E0 and E0+3 -> second result dropped, overflow_drop=1 one cycle,
//     first drain intact.
//   5 chained: enable in the cycle the final word is accepted -> done=1, busy stays 1, second
//     result drains fully, overflow_drop=0.
//   6 DRAIN_CARRY_PACK_EN, add, carries in lanes 0,3,15 -> 17th word = 0x00008009, out_hi=1.

Source files
------------

// File: rtl/alu_result_drain.sv
// -----------------------------------------------------------------------------
// alu_result_drain
//   Consumer end of the vector ALU result interface. Follows the ALU
//   enable/op strobe, captures the registered A3 (low/sum) and A4
//   (high/carry) result vectors one cycle after the sampled enable into
//   shadow buffers, then streams them out as LANE_W-bit words over a
//   valid/ready port toward memory writeback.
//
//   Word order: A3 lanes 0..LANES-1, then A4 lanes 0..LANES-1.
//
//   Optional feature macro: DRAIN_CARRY_PACK_EN
//     When defined, an add result (op 0) sends its A4 half as one packed
//     word: bit i = carry (bit 0) of A4 lane i, upper bits zero, out_lane 0.
//     Multiply results are always drained in full.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   alu_enable/alu_op the same strobe/op the ALU samples (0 add, 1 multiply)
//   A3, A4            ALU result vectors, lane i = [LANE_W*i +: LANE_W]
//   out_valid/ready   word stream handshake
//   out_data          word being offered
//   out_lane, out_hi  lane index of the word, 0 = from A3 / 1 = from A4
//   busy              high while capturing or sending
//   done              one-cycle pulse after the final word is accepted
//   overflow_drop     one-cycle pulse when a result had to be discarded
//   dbg_state         FSM state (0 IDLE, 1 CAPT, 2 SEND)
//   dbg_op            latched op of the result being drained
// -----------------------------------------------------------------------------
module alu_result_drain #(
    parameter int LANES  = 16,
    parameter int LANE_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_enable,
    input  logic                       alu_op,
    input  logic [LANES*LANE_W-1:0]    A3,
    input  logic [LANES*LANE_W-1:0]    A4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANE_W-1:0]          out_data,
    output logic [$clog2(LANES)-1:0]   out_lane,
    output logic                       out_hi,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow_drop,
    output logic [1:0]                 dbg_state,
    output logic                       dbg_op
);
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t                    state;
    logic                      op_q;
    logic [LANES*LANE_W-1:0]   a3_q;
    logic [LANES*LANE_W-1:0]   a4_q;
    logic [IDX_W-1:0]          idx;
    logic                      hi;

    logic                      pack_mode;
    logic [LANE_W-1:0]         carry_word;
    logic [LANE_W-1:0]         word_sel;
    logic                      last_word;
    logic                      accept;

`ifdef DRAIN_CARRY_PACK_EN
    always_comb begin
        carry_word = '0;
        for (int i = 0; i < LANES; i++) begin
            carry_word[i] = a4_q[LANE_W*i];
        end
    end
    assign pack_mode = ~op_q;
`else
    assign carry_word = '0;
    assign pack_mode  = 1'b0;
`endif

    // Handshake: a word transfers on a rising edge where out_valid & out_ready.
    // Once out_valid rises, out_data/out_lane/out_hi are held (they depend only
    // on idx/hi/shadow registers) until that transfer happens.
    assign accept    = out_valid & out_ready;
    // In packed mode the A4 half is a single word, so the first hi word is last.
    assign last_word = hi & (pack_mode | (idx == IDX_W'(LANES-1)));

    always_comb begin
        if (!hi)
            word_sel = a3_q[LANE_W*idx +: LANE_W];
        else if (pack_mode)
            word_sel = carry_word;
        else
            word_sel = a4_q[LANE_W*idx +: LANE_W];
    end

    assign out_data  = out_valid ? word_sel : '0;
    assign out_lane  = idx;
    assign out_hi    = hi;
    assign dbg_state = state;
    assign dbg_op    = op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            op_q          <= 1'b0;
            a3_q          <= '0;
            a4_q          <= '0;
            idx           <= '0;
            hi            <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow_drop <= 1'b0;
        end else begin
            done          <= 1'b0;
            overflow_drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (alu_enable) begin
                        state <= S_CAPT;
                        op_q  <= alu_op;
                        busy  <= 1'b1;
                    end
                end
                S_CAPT: begin
                    // The ALU presents the result of the enable that moved us here.
                    a3_q      <= A3;
                    a4_q      <= A4;
                    idx       <= '0;
                    hi        <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_SEND;
                    if (alu_enable)
                        overflow_drop <= 1'b1;
                end
                S_SEND: begin
                    if (accept) begin
                        if (last_word) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            idx       <= '0;
                            hi        <= 1'b0;
                            // An enable coinciding with the final transfer chains
                            // straight into the next capture.
                            if (alu_enable) begin
                                state <= S_CAPT;
                                op_q  <= alu_op;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (idx == IDX_W'(LANES-1)) begin
                            idx <= '0;
                            hi  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    if (alu_enable && !(accept && last_word))
                        overflow_drop <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_drain.sv
// -----------------------------------------------------------------------------
// tb_alu_result_drain
//   Directed bench for alu_result_drain. Drives ALU result vectors directly
//   with hand-computed values, consumes the word stream and compares every
//   offered word, the status pulses and the FSM state.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_result_drain;
    localparam int LANES  = 16;
    localparam int LANE_W = 32;
`ifdef DRAIN_CARRY_PACK_EN
    localparam bit PACK = 1'b1;
`else
    localparam bit PACK = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         alu_enable;
    logic         alu_op;
    logic [511:0] A3;
    logic [511:0] A4;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [3:0]   out_lane;
    logic         out_hi;
    logic         busy;
    logic         done;
    logic         overflow_drop;
    logic [1:0]   dbg_state;
    logic         dbg_op;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [511:0] exp3, exp4, nxt3, nxt4;
    bit           pack_exp;

    alu_result_drain #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk(clk), .rst_n(rst_n), .alu_enable(alu_enable), .alu_op(alu_op),
        .A3(A3), .A4(A4), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lane(out_lane), .out_hi(out_hi),
        .busy(busy), .done(done), .overflow_drop(overflow_drop),
        .dbg_state(dbg_state), .dbg_op(dbg_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int total_words();
        return pack_exp ? LANES + 1 : 2 * LANES;
    endfunction

    task automatic exp_word(input int w, output logic [31:0] d,
                            output logic [31:0] l, output logic [31:0] h);
        if (w < LANES) begin
            d = exp3[32*w +: 32];
            l = w;
            h = 0;
        end else if (pack_exp) begin
            d = '0;
            for (int i = 0; i < LANES; i++) d[i] = exp4[32*i];
            l = 0;
            h = 1;
        end else begin
            d = exp4[32*(w-LANES) +: 32];
            l = w - LANES;
            h = 1;
        end
    endtask

    // Called on a falling edge in IDLE; returns on the falling edge after the
    // capture edge, with the first word on offer.
    task automatic start_txn(input logic op, input bit b2b);
        alu_op     = op;
        alu_enable = 1'b1;
        A3         = exp3;
        A4         = exp4;
        pack_exp   = PACK && (op == 1'b0);
        @(negedge clk);
        check("capt_state", dbg_state, 1);
        check("capt_busy", busy, 1);
        check("capt_valid", out_valid, 0);
        check("capt_op", dbg_op, op);
        alu_enable = b2b;
        @(negedge clk);
        alu_enable = 1'b0;
        check("send_state", dbg_state, 2);
        // Later ALU activity must not reach the drain.
        A3 = {16{32'hDEAD_BEEF}};
        A4 = {16{32'hFEED_F00D}};
    endtask

    task automatic drain(input int nwords, input bit toggle, input int en_iter, input bit ovf0);
        int          w = 0;
        int          it = 0;
        bit          acc;
        bit          prev_en = ovf0;
        bit          prev_last = 1'b0;
        logic [31:0] ed, el, eh;
        while (w < nwords && it < 200) begin
            out_ready  = toggle ? (it % 2 == 0) : 1'b1;
            alu_enable = (it == en_iter);
            if (alu_enable) begin
                A3 = nxt3;
                A4 = nxt4;
            end
            exp_word(w, ed, el, eh);
            check("valid", out_valid, 1);
            check("data", out_data, ed);
            check("lane", out_lane, el);
            check("hi", out_hi, eh);
            check("busy", busy, 1);
            check("done_early", done, 0);
            check("ovf", overflow_drop, prev_en && !prev_last);
            acc       = out_valid && out_ready;
            prev_en   = alu_enable;
            prev_last = acc && (w == nwords - 1);
            if (acc) w++;
            @(negedge clk);
            it++;
        end
        alu_enable = 1'b0;
        out_ready  = 1'b0;
        if (w < nwords) check("drain_timeout", w, nwords);
    endtask

    task automatic finish_check();
        check("end_done", done, 1);
        check("end_valid", out_valid, 0);
        check("end_busy", busy, 0);
        check("end_state", dbg_state, 0);
        check("end_ovf", overflow_drop, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_state", dbg_state, 0);
    endtask

    initial begin
        logic [31:0] ed, el, eh;
        rst_n      = 1'b0;
        alu_enable = 1'b0;
        alu_op     = 1'b0;
        out_ready  = 1'b0;
        A3         = '0;
        A4         = '0;
        pack_exp   = 1'b0;
        nxt3       = {16{32'hBAD0_BAD0}};
        nxt4       = {16{32'hBAD1_BAD1}};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow_drop, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", dbg_state, 0);

        // Add, ready held high: A1=i, A2=0xFFFFFFFF per lane.
        for (int i = 0; i < LANES; i++) begin
            exp3[32*i +: 32] = (i == 0) ? 32'hFFFF_FFFF : 32'(i - 1);
            exp4[32*i +: 32] = (i == 0) ? 32'h0 : 32'h1;
        end
        start_txn(1'b0, 1'b0);
        drain(total_words(), 1'b0, -1, 1'b0);
        finish_check();

        // Reset in the middle of a drain, with word 5 on offer.
        start_txn(1'b0, 1'b0);
        drain(5, 1'b0, -1, 1'b0);
        exp_word(5, ed, el, eh);
        check("w5_data", out_data, ed);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_lane", out_lane, 0);
        check("mid_rst_hi", out_hi, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_valid", out_valid, 0);
        end

        // Multiply 0x10000*0x30000 with ready toggling.
        exp3 = {16{32'h0000_0000}};
        exp4 = {16{32'h0000_0003}};
        start_txn(1'b1, 1'b0);
        drain(total_words(), 1'b1, -1, 1'b0);
        finish_check();

        // Overflow: second enable two cycles into SEND is dropped.
        for (int i = 0; i < LANES; i++) begin
            exp3[32*i +: 32] = 32'(i * 32'h100);
            exp4[32*i +: 32] = 32'h1;
        end
        start_txn(1'b0, 1'b0);
        drain(total_words(), 1'b0, 1, 1'b0);
        finish_check();

        // Back-to-back enable during CAPT: dropped, E0 result drained intact.
        exp3 = {16{32'h0002_0001}};
        exp4 = {16{32'h0000_0001}};
        start_txn(1'b1, 1'b1);
        drain(total_words(), 1'b0, -1, 1'b1);
        finish_check();

        // Chained: enable on the final accepted word starts the next capture.
        for (int i = 0; i < LANES; i++) begin
            exp3[32*i +: 32] = (i == 0) ? 32'hFFFF_FFFF : 32'(i - 1);
            exp4[32*i +: 32] = (i == 0) ? 32'h0 : 32'h1;
        end
        nxt3   = {16{32'h0002_0001}};
        nxt4   = {16{32'h0000_0001}};
        start_txn(1'b0, 1'b0);
        alu_op = 1'b1;
        drain(total_words(), 1'b0, total_words() - 1, 1'b0);
        check("chain_done", done, 1);
        check("chain_busy", busy, 1);
        check("chain_state", dbg_state, 1);
        check("chain_ovf", overflow_drop, 0);
        check("chain_op", dbg_op, 1);
        @(negedge clk);
        check("chain_send", dbg_state, 2);
        check("chain_ovf2", overflow_drop, 0);
        exp3     = nxt3;
        exp4     = nxt4;
        pack_exp = 1'b0;
        A3       = {16{32'hDEAD_BEEF}};
        A4       = {16{32'hFEED_F00D}};
        drain(total_words(), 1'b0, -1, 1'b0);
        finish_check();

        // Add with carries in lanes 0, 3, 15; A3 lane i = i.
        for (int i = 0; i < LANES; i++) begin
            exp3[32*i +: 32] = 32'(i);
            exp4[32*i +: 32] = (i == 0 || i == 3 || i == 15) ? 32'h1 : 32'h0;
        end
        nxt3 = {16{32'hBAD0_BAD0}};
        nxt4 = {16{32'hBAD1_BAD1}};
        start_txn(1'b0, 1'b0);
`ifdef DRAIN_CARRY_PACK_EN
        drain(LANES, 1'b0, -1, 1'b0);
        out_ready = 1'b1;
        check("pack_valid", out_valid, 1);
        check("pack_word", out_data, 32'h0000_8009);
        check("pack_hi", out_hi, 1);
        check("pack_lane", out_lane, 0);
        @(negedge clk);
        out_ready = 1'b0;
`else
        drain(total_words(), 1'b0, -1, 1'b0);
`endif
        finish_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
